// File: rtl/clock_pkg.sv
// Shared definitions for the clock front end: repeat FSM states and default
// board timing constants used by the button conditioner and the tick prescaler.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   localparam int unsigned CLK_FREQ_HZ         = 1_000_000;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 50_000;
   localparam int unsigned REPEAT_DELAY_DEF    = 5_000_000;
   localparam int unsigned REPEAT_PERIOD_DEF   = 1_000_000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: 2-FF synchroniser, counter debounce, debounced level
// and a combinational rise flag for the registered press pulse upstream.
module btn_debounce
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_lvl,
   output logic o_rise_c
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          stable_q, stable_d;
   logic          prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A change is accepted only after s2 has disagreed with stable for a full run.
   always_comb begin
      s1_d     = i_raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      prev_d   = stable_q;
      cnt_d    = cnt_q;
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = s2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_lvl    = stable_q;
   assign o_rise_c = stable_q & ~prev_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw set/up pushbuttons for the clock control FSM; the up
// channel adds hold-to-auto-repeat on top of its debounced press pulse.
module button_conditioner
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_set,
   input  logic i_up,
   output logic o_set_lvl,
   output logic o_set_pulse,
   output logic o_up_lvl,
   output logic o_up_pulse
);

   localparam int unsigned   RW          = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic          set_lvl, set_rise_c;
   logic          up_lvl, up_rise_c;
   logic          set_pulse_q, set_pulse_d;
   logic          up_pulse_q, up_pulse_d;
   rpt_state_e    state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_raw    (i_set),
      .o_lvl    (set_lvl),
      .o_rise_c (set_rise_c)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_raw    (i_up),
      .o_lvl    (up_lvl),
      .o_rise_c (up_rise_c)
   );

   // Release wins over any repeat expiry landing on the same cycle.
   always_comb begin
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      up_pulse_d  = 1'b0;
      set_pulse_d = set_rise_c;
      if (!up_lvl) begin
         state_d = IDLE;
         rcnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (up_rise_c) begin
                  up_pulse_d = 1'b1;
                  rcnt_d     = '0;
                  state_d    = DELAY;
               end
            end
            DELAY: begin
               if (rcnt_q == DELAY_LAST) begin
                  up_pulse_d = 1'b1;
                  rcnt_d     = '0;
                  state_d    = REPEAT;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            REPEAT: begin
               if (rcnt_q == PERIOD_LAST) begin
                  up_pulse_d = 1'b1;
                  rcnt_d     = '0;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         rcnt_q      <= '0;
         set_pulse_q <= 1'b0;
         up_pulse_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         set_pulse_q <= set_pulse_d;
         up_pulse_q  <= up_pulse_d;
      end
   end

   assign o_set_lvl   = set_lvl;
   assign o_up_lvl    = up_lvl;
   assign o_set_pulse = set_pulse_q;
   assign o_up_pulse  = up_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a window/timestamp reference model
// checked every cycle, plus hand-computed expectations at fixed edges.
module tb_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 16;
   localparam int RP = 4;
   localparam int NLIT = 43;

   logic clk = 1'b0;
   logic rst_n;
   logic set_raw;
   logic up_raw;
   logic o_set_lvl, o_set_pulse, o_up_lvl, o_up_pulse;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_set       (set_raw),
      .i_up        (up_raw),
      .o_set_lvl   (o_set_lvl),
      .o_set_pulse (o_set_pulse),
      .o_up_lvl    (o_up_lvl),
      .o_up_pulse  (o_up_pulse)
   );

   int cyc   = 0;
   int n_chk = 0;
   int n_bad = 0;

   // Reference state: raw sample history and debounced levels of the last two edges.
   logic [DB+1:0] hs = '0, hu = '0;
   logic ms_st = 1'b0, ms_old = 1'b0, mu_st = 1'b0, mu_old = 1'b0;
   int   anchor = -1;
   logic e_sl = 1'b0, e_sp = 1'b0, e_ul = 1'b0, e_up = 1'b0;

   // Edge number, signal (0 set_lvl, 1 set_pulse, 2 up_lvl, 3 up_pulse), value.
   int   lit_cyc [NLIT] = '{3, 3, 3, 3, 8, 8, 9, 9, 9, 9,
                            10, 10, 11, 11, 25, 26, 27, 29, 30, 34,
                            36, 36, 36, 36, 50, 51, 52, 53, 150, 151,
                            175, 176, 177, 178, 193, 197, 213, 215, 216, 217,
                            236, 237, 253};
   int   lit_sig [NLIT] = '{0, 1, 2, 3, 0, 2, 0, 1, 2, 3,
                            1, 3, 1, 3, 3, 3, 3, 3, 3, 3,
                            0, 1, 2, 3, 0, 0, 1, 1, 0, 0,
                            2, 2, 3, 3, 3, 3, 3, 2, 2, 3,
                            2, 3, 3};
   logic lit_val [NLIT] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0,
                            1, 1, 0, 0, 0, 1, 0, 0, 1, 1,
                            0, 0, 0, 0, 0, 1, 1, 0, 1, 0,
                            0, 1, 1, 0, 1, 1, 1, 1, 0, 0,
                            1, 1, 1};

   function automatic logic flips(input logic [DB+1:0] h, input logic st);
      for (int j = 2; j <= DB + 1; j++) begin
         if (h[j] == st) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin : model
      logic [DB+1:0] nhs, nhu;
      logic          ns, nu;
      int            edge_n, d;
      edge_n = cyc + 1;
      cyc <= edge_n;
      if (!rst_n) begin
         hs     <= '0;
         hu     <= '0;
         ms_st  <= 1'b0;
         ms_old <= 1'b0;
         mu_st  <= 1'b0;
         mu_old <= 1'b0;
         anchor <= -1;
         e_sl   <= 1'b0;
         e_sp   <= 1'b0;
         e_ul   <= 1'b0;
         e_up   <= 1'b0;
      end else begin
         nhs = {hs[DB:0], set_raw};
         nhu = {hu[DB:0], up_raw};
         ns  = flips(nhs, ms_st) ? ~ms_st : ms_st;
         nu  = flips(nhu, mu_st) ? ~mu_st : mu_st;
         e_sl <= ns;
         e_ul <= nu;
         e_sp <= ms_st & ~ms_old;
         e_up <= 1'b0;
         if (!mu_st) begin
            anchor <= -1;
         end else if (!mu_old) begin
            e_up   <= 1'b1;
            anchor <= edge_n;
         end else if (anchor >= 0) begin
            d = edge_n - anchor;
            e_up <= (d == RD) || ((d > RD) && (((d - RD) % RP) == 0));
         end
         hs     <= nhs;
         hu     <= nhu;
         ms_old <= ms_st;
         ms_st  <= ns;
         mu_old <= mu_st;
         mu_st  <= nu;
      end
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : compare
      logic act;
      if (cyc >= 1) begin
         chk("set_lvl", o_set_lvl, e_sl);
         chk("set_pulse", o_set_pulse, e_sp);
         chk("up_lvl", o_up_lvl, e_ul);
         chk("up_pulse", o_up_pulse, e_up);
         for (int i = 0; i < NLIT; i++) begin
            if (lit_cyc[i] == cyc) begin
               case (lit_sig[i])
                  0:       act = o_set_lvl;
                  1:       act = o_set_pulse;
                  2:       act = o_up_lvl;
                  default: act = o_up_pulse;
               endcase
               chk($sformatf("lit_sig%0d", lit_sig[i]), act, lit_val[i]);
            end
         end
      end
   end

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      set_raw = 1'b1;
      up_raw  = 1'b1;
      wait_to(3);
      rst_n = 1'b1;
      // Both held: simultaneous pulses at edge 10, up repeats, then reset mid-REPEAT.
      wait_to(35);
      rst_n   = 1'b0;
      set_raw = 1'b0;
      up_raw  = 1'b0;
      wait_to(37);
      rst_n = 1'b1;
      wait_to(45);
      set_raw = 1'b1;
      wait_to(145);
      set_raw = 1'b0;
      // Bounce on up: two 3-cycle high runs, then held through auto-repeat.
      wait_to(160);
      up_raw = 1'b1;
      wait_to(163);
      up_raw = 1'b0;
      wait_to(165);
      up_raw = 1'b1;
      wait_to(168);
      up_raw = 1'b0;
      wait_to(170);
      up_raw = 1'b1;
      // Level falls at edge 216 while the repeat count reaches its last value.
      wait_to(210);
      up_raw = 1'b0;
      wait_to(230);
      up_raw = 1'b1;
      wait_to(255);
      up_raw = 1'b0;
      wait_to(280);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
